// File: rtl/dram_frame_unpacker.sv
`timescale 1ns/1ps
// dram_frame_unpacker
// Turns the 64-bit word stream from the DRAM frame reader into one pixel
// per cycle, tagged with start-of-frame, end-of-line and end-of-frame
// markers. The reader always fetches whole 16-word bursts, so any padding
// words after the last pixel are popped and dropped before the next frame
// starts. That keeps every frame aligned to a word boundary.
module dram_frame_unpacker #(
  parameter int PIX_W = 8,
  parameter int DIM_W = 12
) (
  input  logic             fclk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [63:0]      din,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             pix_eof,
  output logic             frame_done,
  output logic             busy
);

  localparam int LANES  = 64 / PIX_W;
  localparam int LANE_W = $clog2(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [DIM_W-1:0] width_q;
  logic [DIM_W-1:0] height_q;
  logic [DIM_W-1:0] x;
  logic [DIM_W-1:0] y;
  logic [63:0]      hold_data;
  logic             hold_valid;
  logic [LANE_W-1:0] lane;
  logic [3:0]       burst_cnt;

  logic             last_col;
  logic             last_row;
  logic             last_lane;
  logic             accept;
  logic [31:0]      lane_shift;
  logic [63:0]      shifted;

  assign last_col  = (x == width_q - DIM_W'(1));
  assign last_row  = (y == height_q - DIM_W'(1));
  assign last_lane = (lane == LAST_LANE);

  // Lane 0 sits in the least-significant bits of the held word.
  assign lane_shift = 32'(lane) * 32'(PIX_W);
  assign shifted    = hold_data >> lane_shift;
  assign pix_data   = shifted[PIX_W-1:0];

  assign pix_valid = hold_valid && (state == RUN);
  assign pix_sof   = pix_valid && (x == '0) && (y == '0);
  assign pix_eol   = pix_valid && last_col;
  assign pix_eof   = pix_eol && last_row;
  assign accept    = pix_valid && pix_ready;
  assign busy      = (state != IDLE);

  // Pop the reader only when a word is actually present. In RUN we pop into
  // an empty holding register, or when the final lane leaves and more pixels
  // are still owed. In DRAIN every word that shows up is padding.
  always_comb begin
    din_ready = 1'b0;
    case (state)
      RUN:     din_ready = din_valid && (!hold_valid || (accept && last_lane && !pix_eof));
      DRAIN:   din_ready = din_valid;
      default: din_ready = 1'b0;
    endcase
  end

  // Frame sequencer: latches geometry, walks lanes and x/y, counts words
  // against the 16-word burst, and drives the registered handshake outputs.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      width_q    <= '0;
      height_q   <= '0;
      x          <= '0;
      y          <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      lane       <= '0;
      burst_cnt  <= '0;
      cfg_ready  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            width_q    <= cfg_width;
            height_q   <= cfg_height;
            x          <= '0;
            y          <= '0;
            lane       <= '0;
            burst_cnt  <= '0;
            hold_valid <= 1'b0;
            cfg_ready  <= 1'b0;
            if ((cfg_width == '0) || (cfg_height == '0)) begin
              state <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (din_ready) begin
            hold_data  <= din;
            hold_valid <= 1'b1;
            lane       <= '0;
            burst_cnt  <= burst_cnt + 4'd1;
          end
          if (accept) begin
            if (last_col) begin
              x <= '0;
              y <= y + DIM_W'(1);
            end else begin
              x <= x + DIM_W'(1);
            end
            if (pix_eof) begin
              hold_valid <= 1'b0;
              if (burst_cnt == 4'd0) begin
                state <= DONE;
              end else begin
                state <= DRAIN;
              end
            end else if (!din_ready) begin
              lane <= lane + LANE_W'(1);
              if (last_lane) begin
                hold_valid <= 1'b0;
              end
            end
          end
        end
        DRAIN: begin
          if (din_ready) begin
            burst_cnt <= burst_cnt + 4'd1;
            if (burst_cnt == 4'hF) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          cfg_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_frame_unpacker.sv
`timescale 1ns/1ps
// tb_dram_frame_unpacker
// Randomised frames go through the unpacker and are checked against a
// frame-level model. For each frame the expected pixel list comes straight
// from the source words. The model also predicts the word count (pixel words
// rounded up to a whole 16-word burst) and the frame_done timing.
module tb_dram_frame_unpacker;

  localparam int PIX_W = 8;
  localparam int DIM_W = 12;
  localparam int LANES = 64 / PIX_W;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eol;
    logic             eof;
  } pix_t;

  logic             fclk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [DIM_W-1:0] cfg_width = '0;
  logic [DIM_W-1:0] cfg_height = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic [63:0]      din = '0;
  logic             pix_valid;
  logic             pix_ready = 1'b0;
  logic [PIX_W-1:0] pix_data;
  logic             pix_sof;
  logic             pix_eol;
  logic             pix_eof;
  logic             frame_done;
  logic             busy;

  pix_t        exp_q[$];
  pix_t        got_q[$];
  logic [63:0] src_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int din_mode = 0;
  int starve = 0;
  int data_words = 0;
  int frame_pops = 0;
  int done_cnt = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int sof_cyc = 0;
  int eof_cyc = 0;
  int last_pop_cyc = 0;
  logic expect_valid = 1'b0;
  logic prev_stall = 1'b0;

  dram_frame_unpacker #(.PIX_W(PIX_W), .DIM_W(DIM_W)) dut (
    .fclk       (fclk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din        (din),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .pix_eof    (pix_eof),
    .frame_done (frame_done),
    .busy       (busy)
  );

  // Free-running 10 ns clock.
  always #5 fclk = ~fclk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Source and sink driver: acts as the FWFT reader and the pixel consumer.
  initial begin : driver
    forever begin
      @(negedge fclk);
      if (!rst_n || src_q.size() == 0) begin
        din_valid = 1'b0;
      end else if (starve > 0) begin
        din_valid = 1'b0;
        starve--;
      end else if (din_mode == 1) begin
        din_valid = ($urandom_range(3, 0) != 0);
      end else begin
        din_valid = 1'b1;
      end
      din = (src_q.size() > 0) ? src_q[0] : 64'h0;
      case (rdy_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ~pix_ready;
        default: pix_ready = ($urandom_range(1, 0) == 1);
      endcase
    end
  end

  // Compare process: samples just before each rising edge, checks against the model.
  initial begin : monitor
    pix_t exp_p;
    forever begin
      @(negedge fclk);
      #4;
      cyc++;
      if (!rst_n) begin
        expect_valid = 1'b0;
        prev_stall   = 1'b0;
      end else begin
        checkOutput("din_ready_gated", {63'b0, din_ready & ~din_valid}, 64'h0);
        if (expect_valid) checkOutput("pop_to_pixel_latency", {63'b0, pix_valid}, 64'h1);
        if (prev_stall) checkOutput("valid_held_while_stalled", {63'b0, pix_valid}, 64'h1);
        expect_valid = 1'b0;
        if (!pix_valid) begin
          checkOutput("markers_unqualified", {61'b0, pix_sof, pix_eol, pix_eof}, 64'h0);
        end else if (exp_q.size() == 0) begin
          checkOutput("unexpected_pixel", {63'b0, pix_valid}, 64'h0);
        end else begin
          exp_p = exp_q[0];
          checkOutput("pix_data", {56'b0, pix_data}, {56'b0, exp_p.data});
          checkOutput("pix_markers", {61'b0, pix_sof, pix_eol, pix_eof},
                      {61'b0, exp_p.sof, exp_p.eol, exp_p.eof});
          if (pix_ready) begin
            got_q.push_back({pix_data, pix_sof, pix_eol, pix_eof});
            if (pix_sof) sof_cyc = cyc;
            if (pix_eof) eof_cyc = cyc;
            void'(exp_q.pop_front());
          end
        end
        prev_stall = pix_valid & ~pix_ready;
        if (din_valid & din_ready) begin
          if (src_q.size() > 0) void'(src_q.pop_front());
          if (frame_pops < data_words) expect_valid = 1'b1;
          frame_pops++;
          last_pop_cyc = cyc;
        end
        if (cfg_valid & cfg_ready) begin
          acc_cyc    = cyc;
          frame_pops = 0;
        end
        if (frame_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic releaseReset();
    repeat (2) @(negedge fclk);
    rst_n = 1'b1;
    #4;
    checkOutput("cfg_ready_before_first_edge", {63'b0, cfg_ready}, 64'h0);
    @(negedge fclk);
    #4;
    checkOutput("cfg_ready_after_release", {63'b0, cfg_ready}, 64'h1);
  endtask

  task automatic asyncResetMidFrame();
    @(posedge fclk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_outputs_low",
                {56'b0, cfg_ready, din_ready, pix_valid, pix_sof, pix_eol, pix_eof, frame_done, busy}, 64'h0);
    checkOutput("reset_pix_data", {56'b0, pix_data}, 64'h0);
    src_q.delete();
    exp_q.delete();
    got_q.delete();
    data_words = 0;
    releaseReset();
  endtask

  // One frame: builds source words and the expected pixels, hands over the
  // geometry, then waits for frame_done and checks the frame totals.
  task automatic applyStimulus(input int w, input int h, input bit seq, input int rmode,
                               input int dmode, input int starve_at, input int reset_at);
    int n, dw, total, budget, start_done;
    bit accepted, starved;
    logic [63:0] word;
    pix_t p;
    n     = w * h;
    dw    = (n + LANES - 1) / LANES;
    total = (n == 0) ? 0 : ((dw + 15) / 16) * 16;
    for (int i = 0; i < total; i++) begin
      if (seq) begin
        for (int b = 0; b < 8; b++) word[b*8 +: 8] = 8'(8 * i + b);
      end else begin
        word = {$urandom, $urandom};
      end
      src_q.push_back(word);
      for (int l = 0; l < LANES; l++) begin
        int k;
        k = i * LANES + l;
        if (k < n) begin
          p.data = word[l*PIX_W +: PIX_W];
          p.sof  = (k == 0);
          p.eol  = ((k % w) == w - 1);
          p.eof  = (k == n - 1);
          exp_q.push_back(p);
        end
      end
    end
    data_words = dw;
    rdy_mode   = rmode;
    din_mode   = dmode;
    got_q.delete();
    start_done = done_cnt;
    $display("[TB] frame %0dx%0d, %0d words, ready mode %0d, source mode %0d", w, h, total, rmode, dmode);

    cfg_width  = DIM_W'(w);
    cfg_height = DIM_W'(h);
    accepted   = 1'b0;
    budget     = 0;
    while (!accepted && budget < 50) begin
      @(negedge fclk);
      cfg_valid = 1'b1;
      #4;
      accepted = cfg_ready;
      budget++;
    end
    @(negedge fclk);
    cfg_valid  = 1'b0;
    cfg_width  = DIM_W'($urandom);
    cfg_height = DIM_W'($urandom);
    checkOutput("cfg_accepted", {63'b0, accepted}, 64'h1);

    budget  = 0;
    starved = 1'b0;
    while ((done_cnt == start_done) && (budget < 4000)) begin
      @(negedge fclk);
      budget++;
      if (starve_at > 0 && !starved && got_q.size() >= starve_at) begin
        starve  = 5;
        starved = 1'b1;
      end
      if (reset_at > 0 && got_q.size() >= reset_at) begin
        asyncResetMidFrame();
        return;
      end
    end
    checkOutput("frame_done_seen", 64'(done_cnt - start_done), 64'h1);
    checkOutput("pixel_count", 64'(got_q.size()), 64'(n));
    checkOutput("pop_count", 64'(frame_pops), 64'(total));
    if (n == 0) begin
      checkOutput("empty_frame_done_delay", 64'(done_cyc - acc_cyc), 64'h2);
    end else if (total > dw) begin
      checkOutput("done_after_drain", 64'(done_cyc - last_pop_cyc), 64'h2);
    end else begin
      checkOutput("done_after_eof", 64'(done_cyc - eof_cyc), 64'h2);
    end
    if (n > 0 && rmode == 0 && dmode == 0 && starve_at == 0) begin
      checkOutput("full_rate_throughput", 64'(eof_cyc - sof_cyc), 64'(n - 1));
    end
    repeat (3) @(negedge fclk);
    #4;
    checkOutput("frame_done_once", 64'(done_cnt - start_done), 64'h1);
    checkOutput("idle_after_frame", {62'b0, busy, cfg_ready}, 64'h1);
  endtask

  initial begin : main
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_state",
                {56'b0, cfg_ready, din_ready, pix_valid, pix_sof, pix_eol, pix_eof, frame_done, busy}, 64'h0);
    checkOutput("reset_pix_data0", {56'b0, pix_data}, 64'h0);
    releaseReset();

    // 16x2 with byte-counting words: pixels 0x00..0x1F, 12 padding words.
    applyStimulus(16, 2, 1'b1, 0, 0, 0, 0);
    checkOutput("t1_pops", 64'(frame_pops), 64'd16);
    if (got_q.size() == 32) begin
      checkOutput("t1_pixel0",  64'(got_q[0]),  {53'b0, 8'h00, 3'b100});
      checkOutput("t1_pixel15", 64'(got_q[15]), {53'b0, 8'h0F, 3'b010});
      checkOutput("t1_pixel16", 64'(got_q[16]), {53'b0, 8'h10, 3'b000});
      checkOutput("t1_pixel31", 64'(got_q[31]), {53'b0, 8'h1F, 3'b011});
    end

    // One and a half words: upper lanes of word 1 dropped, 14 drain pops.
    applyStimulus(12, 1, 1'b0, 0, 0, 0, 0);
    checkOutput("t2_pops", 64'(frame_pops), 64'd16);
    applyStimulus(4, 1, 1'b1, 0, 0, 0, 0);
    if (got_q.size() == 4) begin
      checkOutput("t2_next_first", 64'(got_q[0]), {53'b0, 8'h00, 3'b100});
      checkOutput("t2_next_last",  64'(got_q[3]), {53'b0, 8'h03, 3'b011});
    end

    // Backpressure on every other cycle.
    applyStimulus(8, 8, 1'b0, 1, 0, 0, 0);

    // Upstream starvation mid-frame.
    applyStimulus(24, 3, 1'b0, 0, 0, 10, 0);

    // Degenerate geometry.
    applyStimulus(0, 5, 1'b0, 0, 0, 0, 0);
    checkOutput("t5_no_pops", 64'(frame_pops), 64'd0);
    applyStimulus(5, 0, 1'b0, 0, 0, 0, 0);

    // Single-column frame and an exactly-one-burst frame (no drain).
    applyStimulus(1, 3, 1'b0, 2, 1, 0, 0);
    applyStimulus(128, 1, 1'b0, 0, 0, 0, 0);

    // Randomised geometry and flow control.
    for (int f = 0; f < 5; f++) begin
      applyStimulus($urandom_range(40, 1), $urandom_range(6, 1), 1'b0,
                    $urandom_range(2, 0), $urandom_range(1, 0), 0, 0);
    end

    // Asynchronous reset mid-frame, then a clean frame.
    applyStimulus(32, 4, 1'b0, 0, 0, 0, 20);
    applyStimulus(10, 2, 1'b1, 2, 1, 0, 0);
    if (got_q.size() == 20) begin
      checkOutput("post_reset_first", 64'(got_q[0]), {53'b0, 8'h00, 3'b100});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dram_frame_unpacker.md
Name: dram_frame_unpacker

Overview:
- Sits directly downstream of the DRAM frame reader buffer. Consumes its 64-bit word stream (dout_valid/dout_ready/dout) and emits one pixel per cycle with frame and line markers.
- Per-frame geometry arrives over a config handshake.
- The upstream reader always fetches whole 128-byte bursts (16 words). This block therefore discards padding words after the last pixel, so the next frame stays word-aligned.

Parameters:
PIX_W, 8, pixel width in bits; legal values 8, 16, 32; LANES = 64/PIX_W pixels per word
DIM_W, 12, width in bits of the geometry and position counters

Ports:
fclk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_valid  in  1  frame geometry valid
cfg_ready  out  1  frame geometry accepted when cfg_valid && cfg_ready
cfg_width  in  DIM_W  pixels per line
cfg_height  in  DIM_W  lines per frame
din_valid  in  1  upstream word available (reader dout_valid, FIFO not empty)
din_ready  out  1  pop strobe, connects to reader dout_ready (FIFO rd_en)
din  in  64  upstream word; data is valid in the same cycle as din_valid (first-word fall-through)
pix_valid  out  1  pixel valid
pix_ready  in  1  downstream accepts pixel
pix_data  out  PIX_W  pixel
pix_sof  out  1  first pixel of frame (x==0, y==0)
pix_eol  out  1  last pixel of line (x==width-1)
pix_eof  out  1  last pixel of frame
frame_done  out  1  one-cycle pulse when the frame (including drain) completes
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low): state=IDLE, hold_valid=0, lane=0, x=0, y=0, burst_cnt=0. Outputs: cfg_ready=0, din_ready=0, pix_valid=0, pix_sof/pix_eol/pix_eof=0, frame_done=0, busy=0, pix_data=0.
- Reset mid-frame discards all state. Upstream is reset by the same rst_n.
- din_ready is combinational and is never asserted unless din_valid=1. An empty FIFO must never be popped.
- States:
  - IDLE:
    - cfg_ready=1 (registered; asserts 1 cycle after reset release).
    - On cfg accept: latch width/height, clear x/y/lane/burst_cnt.
    - If width==0 or height==0: go to DONE. Otherwise go to RUN.
  - RUN:
    - Holding register hold_data/hold_valid plus lane index.
    - pix_valid=hold_valid. pix_data = hold_data[lane*PIX_W +: PIX_W]; lane 0 is the least-significant bits (little-endian).
    - Pixel accepted = pix_valid && pix_ready. On accept: lane++, and x++; when x reaches width-1, x returns to 0 and y increments.
    - Pop: din_ready = din_valid && (!hold_valid || (accept && lane==LANES-1 && !pix_eof)).
      - On a pop, the word loads into hold next cycle with lane=0 and burst_cnt incremented (4-bit, wraps at 16).
      - When hold empties without a pop, hold_valid is cleared.
    - Pixels are packed contiguously; lines may straddle words.
    - Throughput: 1 pixel/cycle sustained. Latency din pop -> pix_valid is 1 cycle.
    - On accept of the pix_eof pixel: unused lanes of the current word are discarded and hold_valid is cleared. Then go to DONE if burst_cnt==0, else go to DRAIN.
  - DRAIN:
    - din_ready=din_valid; every popped word is discarded, burst_cnt++.
    - When a pop brings burst_cnt to 0: go to DONE.
    - pix_valid=0 throughout.
  - DONE: frame_done=1 for exactly one cycle, then go to IDLE.
- Markers (combinational from x, y):
  - pix_sof = (x==0 && y==0).
  - pix_eol = (x==width-1).
  - pix_eof = pix_eol && (y==height-1).
  - All three are qualified by pix_valid.
- pix_data and the markers hold stable while pix_valid && !pix_ready.
- Arithmetic: x/y compare at DIM_W bits; lane is log2(LANES) bits; burst_cnt is 4 bits modulo 16.
- cfg_valid in states other than IDLE is ignored (cfg_ready=0).

Test Plan:
- PIX_W=8, cfg 16x2, 4 words 0x0706050403020100 … 0x1F1E…18, pix_ready=1 -> pixels 0x00..0x1F in order, one per cycle after first. sof on 0x00; eol on 0x0F and 0x1F; eof on 0x1F. Then 12 padding words popped in DRAIN, frame_done pulses once, total pops = 16.
- PIX_W=16, cfg 6x1 (1.5 words) -> 6 pixels; lanes 2–3 of word 1 discarded; 14 drain pops; frame_done; next cfg accepted and its first pixel comes from pop 17.
- Backpressure: pix_ready toggles 1-0-1 every cycle, cfg 8x8 PIX_W=8 -> pix_data/markers stable while stalled; no extra pops; din_ready never high with din_valid=0; 64 pixels intact.
- Upstream starvation: din_valid low for 5 cycles mid-frame -> pix_valid drops after current word; resumes without loss or duplication.
- cfg 0x5 -> no pops, frame_done pulses 2 cycles after accept, back to IDLE with cfg_ready=1.
- rst_n asserted mid-RUN (asynchronously, off clock edge) -> all outputs 0 immediately; after release the next frame's sof pixel is the first pixel emitted.
